// File: rtl/gobang_geom_pkg.sv
// Board geometry shared by the piece renderer, board drawer and pixel locator.
// Also holds the locator FSM state type and the click-window test.
package gobang_geom_pkg;

    localparam int unsigned X0    = 102;
    localparam int unsigned Y0    = 23;
    localparam int unsigned GRID  = 31;
    localparam int unsigned NLINE = 15;
    localparam int unsigned R     = 15;
    localparam int unsigned R_SQ  = R * R;

    localparam int unsigned X_MIN = X0 - R;
    localparam int unsigned X_MAX = X0 + (NLINE - 1) * GRID + R;
    localparam int unsigned Y_MIN = Y0 - R;
    localparam int unsigned Y_MAX = Y0 + (NLINE - 1) * GRID + R;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StCheck,
        StDone
    } loc_state_e;

    function automatic logic in_window(input logic [9:0] x, input logic [9:0] y);
        return (x >= 10'(X_MIN)) && (x <= 10'(X_MAX)) &&
               (y >= 10'(Y_MIN)) && (y <= 10'(Y_MAX));
    endfunction

endpackage

// File: rtl/board_pixel_locator_if.sv
// Request/response bundle between the pointer front-end and the pixel locator.
interface board_pixel_locator_if;

    logic       req_valid;
    logic       req_ready;
    logic [9:0] px;
    logic [9:0] py;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] row;
    logic [3:0] col;
    logic       hit;

    modport master (
        output req_valid, px, py, rsp_ready,
        input  req_ready, rsp_valid, row, col, hit
    );

    modport slave (
        input  req_valid, px, py, rsp_ready,
        output req_ready, rsp_valid, row, col, hit
    );

endinterface

// File: rtl/axis_quantizer.sv
// One axis of the locator: holds the window offset and walks it down one grid
// pitch per step until the residual is below a pitch or the last line is reached.
module axis_quantizer
    import gobang_geom_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic       step_i,
    input  logic [8:0] offset_i,
    output logic [4:0] rem_o,
    output logic [3:0] idx_o,
    output logic       done_o
);

    logic [8:0] rem_q, rem_d;
    logic [3:0] idx_q, idx_d;

    assign done_o = !((rem_q >= 9'(GRID)) && (idx_q < 4'(NLINE - 1)));
    // Once done the residual is at most GRID-1, so five bits carry it.
    assign rem_o  = rem_q[4:0];
    assign idx_o  = idx_q;

    always_comb begin
        rem_d = rem_q;
        idx_d = idx_q;
        if (load_i) begin
            rem_d = offset_i;
            idx_d = '0;
        end else if (step_i && !done_o) begin
            rem_d = rem_q - 9'(GRID);
            idx_d = idx_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            idx_q <= '0;
        end else begin
            rem_q <= rem_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/board_pixel_locator.sv
// Maps a screen pixel to the nearest board intersection and reports whether it
// falls strictly inside that intersection's piece circle.
module board_pixel_locator
    import gobang_geom_pkg::*;
(
    input logic                  clk,
    input logic                  rst_n,
    board_pixel_locator_if.slave bus
);

    loc_state_e state_q, state_d;
    logic       req_ready_q, req_ready_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [3:0] row_q, row_d;
    logic [3:0] col_q, col_d;
    logic       hit_q, hit_d;

    logic       accept, in_win, load, scan;
    logic [8:0] x_off, y_off;
    logic [4:0] x_rem, y_rem;
    logic [3:0] x_idx, y_idx;
    logic       x_done, y_done;

    logic signed [6:0] dx, dy;
    logic [11:0]       sq_x, sq_y;
    logic [12:0]       dist_sq;
    logic              hit_now;

    assign accept = (state_q == StIdle) && bus.req_valid;
    assign in_win = in_window(bus.px, bus.py);
    assign load   = accept && in_win;
    assign scan   = (state_q == StScan);
    assign x_off  = 9'(bus.px - 10'(X_MIN));
    assign y_off  = 9'(bus.py - 10'(Y_MIN));

    axis_quantizer u_quant_x (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (load),
        .step_i   (scan),
        .offset_i (x_off),
        .rem_o    (x_rem),
        .idx_o    (x_idx),
        .done_o   (x_done)
    );

    axis_quantizer u_quant_y (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (load),
        .step_i   (scan),
        .offset_i (y_off),
        .rem_o    (y_rem),
        .idx_o    (y_idx),
        .done_o   (y_done)
    );

    // Residual is measured from the window edge, R pixels before the line.
    assign dx      = $signed({2'b00, x_rem}) - $signed(7'(R));
    assign dy      = $signed({2'b00, y_rem}) - $signed(7'(R));
    assign sq_x    = 12'($unsigned(12'(dx) * 12'(dx)));
    assign sq_y    = 12'($unsigned(12'(dy) * 12'(dy)));
    assign dist_sq = {1'b0, sq_x} + {1'b0, sq_y};
    assign hit_now = dist_sq < 13'(R_SQ);

    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        row_d       = row_q;
        col_d       = col_q;
        hit_d       = hit_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    req_ready_d = 1'b0;
                    if (in_win) begin
                        state_d = StScan;
                    end else begin
                        state_d = StDone;
                        row_d   = '0;
                        col_d   = '0;
                        hit_d   = 1'b0;
                    end
                end
            end
            StScan: begin
                if (x_done && y_done) state_d = StCheck;
            end
            StCheck: begin
                row_d       = y_idx;
                col_d       = x_idx;
                hit_d       = hit_now;
                rsp_valid_d = 1'b1;
                state_d     = StDone;
            end
            StDone: begin
                // Out-of-window requests arrive here with rsp_valid still low.
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                end else if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            row_q       <= '0;
            col_q       <= '0;
            hit_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            row_q       <= row_d;
            col_q       <= col_d;
            hit_q       <= hit_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.row       = row_q;
    assign bus.col       = col_q;
    assign bus.hit       = hit_q;

endmodule

// File: tb/tb_board_pixel_locator.sv
// Self-checking bench for board_pixel_locator: directed corner pixels plus
// random clicks compared against a division-based geometric model.
module tb_board_pixel_locator;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    board_pixel_locator_if bus ();

    board_pixel_locator dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Nearest line by integer division from the window edge, clamped to the last line.
    function automatic void model(input int x, input int y,
                                  output int r, output int c, output int h, output int lat);
        int dx, dy;
        if (x < 87 || x > 551 || y < 8 || y > 472) begin
            r = 0; c = 0; h = 0; lat = 1;
        end else begin
            c = (x - 87) / 31;
            if (c > 14) c = 14;
            r = (y - 8) / 31;
            if (r > 14) r = 14;
            dx  = x - (102 + 31 * c);
            dy  = y - (23 + 31 * r);
            h   = (dx * dx + dy * dy < 225) ? 1 : 0;
            lat = ((r > c) ? r : c) + 2;
        end
    endfunction

    task automatic run_req(input int x, input int y, input int hold);
        int er, ec, eh, el, edges;
        model(x, y, er, ec, eh, el);
        @(negedge clk);
        check_eq($sformatf("req_ready(%0d,%0d)", x, y), 32'(bus.req_ready), 1);
        bus.req_valid = 1'b1;
        bus.px        = 10'(x);
        bus.py        = 10'(y);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.px        = 10'($urandom_range(0, 1023));
        bus.py        = 10'($urandom_range(0, 1023));
        edges = 0;
        while (!bus.rsp_valid && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check_eq($sformatf("latency(%0d,%0d)", x, y), 32'(edges), 32'(el));
        check_eq($sformatf("row(%0d,%0d)", x, y), 32'(bus.row), 32'(er));
        check_eq($sformatf("col(%0d,%0d)", x, y), 32'(bus.col), 32'(ec));
        check_eq($sformatf("hit(%0d,%0d)", x, y), 32'(bus.hit), 32'(eh));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            bus.req_valid = 1'b1;
            bus.px        = 10'($urandom_range(0, 1023));
            bus.py        = 10'($urandom_range(0, 1023));
            @(posedge clk);
            #1;
            check_eq("hold_rsp_valid", 32'(bus.rsp_valid), 1);
            check_eq("hold_req_ready", 32'(bus.req_ready), 0);
            check_eq("hold_row", 32'(bus.row), 32'(er));
            check_eq("hold_col", 32'(bus.col), 32'(ec));
            check_eq("hold_hit", 32'(bus.hit), 32'(eh));
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rsp_drop", 32'(bus.rsp_valid), 0);
        check_eq("ready_back", 32'(bus.req_ready), 1);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        int seen;
        int c, r;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        bus.px        = '0;
        bus.py        = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_req_ready", 32'(bus.req_ready), 1);
        check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        check_eq("rst_row", 32'(bus.row), 0);
        check_eq("rst_col", 32'(bus.col), 0);
        check_eq("rst_hit", 32'(bus.hit), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_req(102, 23, 0);
        run_req(536, 457, 0);
        run_req(116, 23, 0);
        run_req(117, 23, 0);
        run_req(118, 23, 0);
        run_req(50, 100, 0);
        run_req(300, 480, 0);
        run_req(87, 8, 0);
        run_req(551, 472, 0);
        run_req(86, 200, 0);
        run_req(552, 200, 0);

        // Back-pressure with ignored request pulses, then a fresh request.
        run_req(400, 300, 5);
        run_req(250, 150, 0);

        // Abort during SCAN of (400,300).
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.px        = 10'd400;
        bus.py        = 10'd300;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("abort_req_ready", 32'(bus.req_ready), 1);
        check_eq("abort_rsp_valid", 32'(bus.rsp_valid), 0);
        check_eq("abort_row", 32'(bus.row), 0);
        check_eq("abort_col", 32'(bus.col), 0);
        check_eq("abort_hit", 32'(bus.hit), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid) seen = 1;
        end
        check_eq("abort_no_rsp", 32'(seen), 0);
        run_req(400, 300, 0);

        for (int i = 0; i < 120; i++) begin
            run_req($urandom_range(0, 640), $urandom_range(0, 520), i % 7 == 0 ? 2 : 0);
        end
        // Clicks clustered around intersections to exercise hit/miss boundaries.
        for (int i = 0; i < 150; i++) begin
            c = $urandom_range(0, 14);
            r = $urandom_range(0, 14);
            run_req(86 + 31 * c + $urandom_range(0, 32), 7 + 31 * r + $urandom_range(0, 32), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
